pr_elastic: RTL and testbench
=============================

PR_ELASTIC -- requirements
Module: pr_elastic

Interface
REQ-001 SHALL have parameter WIDTH, default 32: payload width in bits, >= 1.
REQ-002 SHALL have parameter DEPTH, default 2: number of register stages, >= 1.
REQ-003 SHALL have parameter RESET_DATA, default '0: payload value loaded on reset and flush.
REQ-004 SHALL have the following ports, one per line.
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream offers in_data.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  out_data valid for downstream.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_data  out  WIDTH  payload of the last stage.
- stall  in  1  freeze all stages.
- flush  in  1  squash all stages.
- stage_valid  out  DEPTH  per-stage valid bits; bit 0 = input stage, bit DEPTH-1 = output stage.
- occupancy  out  $clog2(DEPTH+1)  count of valid stages.

Function
REQ-005 SHALL hold per stage i a valid bit v[i] and a payload register d[i].
REQ-006 SHALL drive out_data = d[DEPTH-1] and out_valid = v[DEPTH-1] & ~stall & ~flush.
REQ-007 SHALL define an output transfer as out_valid & out_ready, and an input transfer as in_valid & in_ready.
REQ-008 SHALL define move[DEPTH-1] = output transfer, and move[i] = v[i] & ~stall & ~flush & (~v[i+1] | move[i+1]) for i < DEPTH-1.
REQ-009 SHALL drive in_ready = ~stall & ~flush & (~v[0] | move[0]), combinationally.
REQ-010 SHALL, when move[i] is true for i < DEPTH-1, copy d[i] to d[i+1] and set v[i+1].
REQ-011 SHALL, on an input transfer, load in_data into d[0] and set v[0].
REQ-012 SHALL clear v[i] when move[i] is true and stage i is not reloaded in the same cycle.
REQ-013 SHALL advance items into empty downstream stages even while out_ready = 0 (bubble collapse).
REQ-014 SHALL leave d[i] unchanged in any cycle in which stage i is not loaded; no X propagation.
REQ-015 SHALL, with stall = 1 and flush = 0, hold every v[i] and d[i] unchanged and complete no transfer.
REQ-016 SHALL, with flush = 1, clear every v[i] and load RESET_DATA into every d[i] at the next edge, regardless of stall.
REQ-017 SHALL give flush priority over stall, and both priority over in_valid and out_ready.
REQ-018 SHALL have a minimum latency of DEPTH cycles, from the input-transfer edge to out_valid.
REQ-019 SHALL sustain a throughput of one transfer per cycle when out_ready = 1 and stall = 0.
REQ-020 SHALL, when full with out_ready = 1, accept a new input in the same cycle as the output transfer.
REQ-021 SHALL drive stage_valid = v, and occupancy = popcount(v), both combinational from registers.
REQ-022 SHALL preserve FIFO order of payloads; no duplication and no loss except by flush or reset.

Reset
REQ-023 SHALL, while rst = 1, force every v[i] = 0 and every d[i] = RESET_DATA, asynchronously.
REQ-024 SHALL, while rst = 1, drive out_valid = 0, stage_valid = 0 and occupancy = 0.
REQ-025 SHALL, on reset asserted mid-stream, discard all in-flight items.
REQ-026 SHALL resume accepting input on the first edge after rst deasserts (in_ready = 1 if stall = 0 and flush = 0).

Verification (WIDTH = 8, DEPTH = 3, RESET_DATA = 0)
REQ-027 SHALL verify reset: rst pulse mid-stream -> out_valid 0, out_data 0x00, occupancy 0, stage_valid 3'b000; after release, in_ready 1.
REQ-028 SHALL verify streaming: push 0x11, 0x22, 0x33, 0x44 back-to-back with out_ready 1 -> 0x11 appears 3 cycles after its accept, then one item per cycle with no gaps, in order.
REQ-029 SHALL verify backpressure: out_ready 0 while pushing 4 items -> 3 accepted, in_ready 0 on the 4th, occupancy 3; then out_ready 1 -> outputs 0x11, 0x22, 0x33, 0x44 in order.
REQ-030 SHALL verify bubble collapse: out_ready 0 and push 0xA5 alone -> stage_valid 001, 010, 100 on successive cycles; a following 0x5A settles at stage_valid 110.
REQ-031 SHALL verify stall: occupancy 2 with stall 1 for 4 cycles -> stage_valid, out_data and occupancy unchanged; out_valid 0 and in_ready 0 throughout; no transfer despite in_valid 1 and out_ready 1.
REQ-032 SHALL verify flush under stall: occupancy 3 with stall 1 and a 1-cycle flush pulse -> next cycle occupancy 0, out_data 0x00, stage_valid 000; the same cycle shows out_valid 0 and in_ready 0.

Source files
------------

// File: rtl/pr_elastic.sv
// pr_elastic: elastic register pipeline with bubble collapse, stall and flush
module pr_elastic #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_data,
  input  logic                           stall,
  input  logic                           flush,
  output logic [DEPTH-1:0]               stage_valid,
  output logic [$clog2(DEPTH+1)-1:0]     occupancy
);
  localparam int OW = $clog2(DEPTH+1);
  logic [DEPTH-1:0] v, move;
  logic [WIDTH-1:0] d [DEPTH];
  logic blk, xfer_in, xfer_out;
  assign blk = stall | flush;
  assign out_valid = v[DEPTH-1] & ~blk;
  assign out_data = d[DEPTH-1];
  assign xfer_out = out_valid & out_ready;
  assign move[DEPTH-1] = xfer_out;
  for (genvar g = 0; g < DEPTH-1; g++) begin : g_mv
    // a stage advances if any later stage is empty or the output drains
    assign move[g] = v[g] & ~blk & (~&v[DEPTH-1:g+1] | xfer_out);
  end
  assign in_ready = ~blk & (~v[0] | move[0]);
  assign xfer_in = in_valid & in_ready;
  assign stage_valid = v;
  // count of occupied stages
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) occupancy = occupancy + OW'(v[i]);
  end
  // stage registers: reset/flush squash everything, otherwise shift along move
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) d[i] <= RESET_DATA;
    end else if (flush) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) d[i] <= RESET_DATA;
    end else begin
      v[0] <= xfer_in | (v[0] & ~move[0]);
      if (xfer_in) d[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        v[i] <= move[i-1] | (v[i] & ~move[i]);
        if (move[i-1]) d[i] <= d[i-1];
      end
    end
  end
endmodule

// File: tb/tb_pr_elastic.sv
// tb_pr_elastic: directed scoreboard bench for pr_elastic (WIDTH=8, DEPTH=3)
module tb_pr_elastic;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, stall, flush;
  logic [7:0] in_data, out_data;
  logic [2:0] stage_valid;
  logic [1:0] occupancy;
  int total = 0, bad = 0, n = 0, pops = 0;
  bit lat_chk = 0;
  logic [7:0] sbq[$];
  int cq[$];
  logic [2:0] sv_hold;
  logic [7:0] od_hold;
  logic [7:0] items [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  pr_elastic #(.WIDTH(8), .DEPTH(3), .RESET_DATA(8'h00)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall(stall), .flush(flush), .stage_valid(stage_valid), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    logic [7:0] e;
    int c;
    #1;
    if (in_valid && in_ready) begin
      sbq.push_back(in_data);
      cq.push_back(n);
    end
    if (out_valid && out_ready) begin
      total++;
      assert (sbq.size() != 0) else begin
        bad++;
        $error("FAIL sb_underflow observed=%0h expected=nonempty", out_data);
      end
      if (sbq.size() != 0) begin
        total--;
        e = sbq.pop_front();
        c = cq.pop_front();
        chk("data", 32'(out_data), 32'(e));
        if (lat_chk) chk("latency", n - c, 3);
        pops++;
      end
    end
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic drain(input int k);
    out_ready = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < k; i++) cyc();
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_data = 0; out_ready = 0; stall = 0; flush = 0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_sv", 32'(stage_valid), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_rel_ready", 32'(in_ready), 1);

    // back-to-back streaming with out_ready high
    lat_chk = 1; pops = 0; out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_data = items[i];
      #1;
      chk("stream_ready", 32'(in_ready), 1);
      cyc();
    end
    drain(6);
    chk("stream_pops", pops, 4);
    chk("stream_sb_empty", sbq.size(), 0);
    lat_chk = 0;

    // backpressure: three fit, fourth waits, then drains in order
    pops = 0; out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_data = items[i];
      #1;
      chk("bp_ready", 32'(in_ready), (i < 3) ? 1 : 0);
      if (i < 3) cyc();
    end
    chk("bp_occ", 32'(occupancy), 3);
    out_ready = 1;
    #1;
    chk("bp_full_accept", 32'(in_ready), 1);
    cyc();
    drain(5);
    chk("bp_pops", pops, 4);

    // bubble collapse while out_ready low
    pops = 0; out_ready = 0;
    in_valid = 1; in_data = 8'hA5;
    cyc();
    in_valid = 0;
    chk("bub_sv0", 32'(stage_valid), 3'b001);
    cyc();
    chk("bub_sv1", 32'(stage_valid), 3'b010);
    cyc();
    chk("bub_sv2", 32'(stage_valid), 3'b100);
    in_valid = 1; in_data = 8'h5A;
    cyc();
    in_valid = 0;
    cyc();
    chk("bub_sv_settle", 32'(stage_valid), 3'b110);
    cyc();
    chk("bub_sv_hold", 32'(stage_valid), 3'b110);
    drain(4);
    chk("bub_pops", pops, 2);

    // stall holds two items for four cycles
    pops = 0; out_ready = 0;
    in_valid = 1; in_data = 8'h66; cyc();
    in_data = 8'h77; cyc();
    in_valid = 0;
    cyc();
    chk("stall_occ_pre", 32'(occupancy), 2);
    sv_hold = stage_valid;
    od_hold = out_data;
    stall = 1; in_valid = 1; in_data = 8'h88; out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stall_out_valid", 32'(out_valid), 0);
      chk("stall_in_ready", 32'(in_ready), 0);
      cyc();
      chk("stall_sv", 32'(stage_valid), 32'(sv_hold));
      chk("stall_od", 32'(out_data), 32'(od_hold));
      chk("stall_occ", 32'(occupancy), 2);
    end
    chk("stall_sb", sbq.size(), 2);
    stall = 0;
    drain(4);
    chk("stall_pops", pops, 2);

    // flush under stall squashes a full pipe
    out_ready = 0;
    in_valid = 1; in_data = 8'h91; cyc();
    in_data = 8'h92; cyc();
    in_data = 8'h93; cyc();
    in_valid = 0;
    chk("fl_occ_pre", 32'(occupancy), 3);
    stall = 1; flush = 1; in_valid = 1; in_data = 8'h99; out_ready = 1;
    #1;
    chk("fl_out_valid", 32'(out_valid), 0);
    chk("fl_in_ready", 32'(in_ready), 0);
    cyc();
    flush = 0;
    sbq.delete(); cq.delete();
    chk("fl_occ", 32'(occupancy), 0);
    chk("fl_od", 32'(out_data), 0);
    chk("fl_sv", 32'(stage_valid), 0);
    stall = 0; in_valid = 0;
    #1;
    chk("fl_ready_after", 32'(in_ready), 1);

    // reset asserted mid-stream
    out_ready = 0;
    in_valid = 1; in_data = 8'hC1; cyc();
    in_data = 8'hC2; cyc();
    in_valid = 0;
    #2;
    rst = 1;
    #1;
    chk("mrst_out_valid", 32'(out_valid), 0);
    chk("mrst_od", 32'(out_data), 0);
    chk("mrst_occ", 32'(occupancy), 0);
    chk("mrst_sv", 32'(stage_valid), 0);
    sbq.delete(); cq.delete();
    @(posedge clk); #1;
    rst = 0;
    #1;
    chk("mrst_ready", 32'(in_ready), 1);
    pops = 0;
    in_valid = 1; in_data = 8'hD1;
    cyc();
    drain(5);
    chk("mrst_resume_pops", pops, 1);
    chk("mrst_sb_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
